// File: rtl/fft_frame_sequencer_if.sv
// Sample stream from upstream into the FFT frame sequencer.
// The upstream side drives valid/data, the sequencer answers with ready.
interface fft_frame_sequencer_if #(
    parameter int IWIDTH = 16
);
    logic                  s_valid;
    logic [2*IWIDTH-1:0]   s_data;
    logic                  s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frames a sample stream into N-point FFT frames; optional zero flush
// of the FFT pipeline on stop is enabled by FFT_SEQ_FLUSH_EN.
module fft_frame_sequencer #(
    parameter int IWIDTH       = 16,
    parameter int LGWIDTH      = 8,
    parameter int PIPE_LATENCY = 6
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
    fft_frame_sequencer_if.slave up,
    output logic                o_ce,
    output logic                o_sync,
    output logic [2*IWIDTH-1:0] o_data,
    input  logic                i_fft_sync,
    output logic [1:0]          o_state,
    output logic [15:0]         o_in_frames,
    output logic [15:0]         o_out_frames
);

    localparam int N = 1 << LGWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef FFT_SEQ_FLUSH_EN
        ST_FLUSH = 2'd2,
`endif
        ST_RUN   = 2'd1
    } state_t;

    state_t               state, state_nx;
    logic [LGWIDTH-1:0]   idx, idx_nx;
    logic                 stop_pend, stop_pend_nx;
    logic                 ce_nx, sync_nx;
    logic [2*IWIDTH-1:0]  data_nx;
    logic                 hs, last, stop_now;

`ifdef FFT_SEQ_FLUSH_EN
    localparam int FLEN = N + PIPE_LATENCY;
    localparam int FW   = $clog2(FLEN + 1);
    logic [FW-1:0]        fcnt, fcnt_nx;
`endif

    assign up.s_ready = (state == ST_RUN);
    assign hs         = up.s_valid && up.s_ready;
    assign last       = (idx == LGWIDTH'(N - 1));
    assign stop_now   = i_stop || stop_pend;
    assign o_state    = state;

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        stop_pend_nx = stop_pend;
        ce_nx        = 1'b0;
        sync_nx      = 1'b0;
        data_nx      = o_data;
`ifdef FFT_SEQ_FLUSH_EN
        fcnt_nx      = fcnt;
`endif
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nx = ST_RUN;
                    idx_nx   = '0;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    ce_nx   = 1'b1;
                    sync_nx = (idx == '0);
                    data_nx = up.s_data;
                    idx_nx  = idx + LGWIDTH'(1);
                end
                // Exit only on a frame boundary: after the last sample,
                // or right away when no frame has been started.
                if (stop_now && ((hs && last) || (!hs && idx == '0))) begin
                    stop_pend_nx = 1'b0;
`ifdef FFT_SEQ_FLUSH_EN
                    state_nx     = ST_FLUSH;
                    fcnt_nx      = '0;
`else
                    state_nx     = ST_IDLE;
`endif
                end else if (stop_now) begin
                    stop_pend_nx = 1'b1;
                end
            end
`ifdef FFT_SEQ_FLUSH_EN
            ST_FLUSH: begin
                // Zeros push the last real frame out of the FFT pipeline.
                ce_nx   = 1'b1;
                data_nx = '0;
                sync_nx = (fcnt[LGWIDTH-1:0] == '0);
                fcnt_nx = fcnt + FW'(1);
                if (fcnt == FW'(FLEN - 1)) begin
                    state_nx = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            stop_pend    <= 1'b0;
            o_ce         <= 1'b0;
            o_sync       <= 1'b0;
            o_data       <= '0;
            o_in_frames  <= '0;
            o_out_frames <= '0;
`ifdef FFT_SEQ_FLUSH_EN
            fcnt         <= '0;
`endif
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            stop_pend <= stop_pend_nx;
            o_ce      <= ce_nx;
            o_sync    <= sync_nx;
            o_data    <= data_nx;
`ifdef FFT_SEQ_FLUSH_EN
            fcnt      <= fcnt_nx;
`endif
            if (hs && last) begin
                o_in_frames <= o_in_frames + 16'd1;
            end
            if (i_fft_sync) begin
                o_out_frames <= o_out_frames + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed plus randomized bench for fft_frame_sequencer with an
// abstract frame-position model (N=8, PIPE_LATENCY=6).
module tb_fft_frame_sequencer;

    localparam int IW  = 16;
    localparam int LG  = 3;
    localparam int N   = 1 << LG;
    localparam int PL  = 6;
`ifdef FFT_SEQ_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          fsync;
    logic          o_ce;
    logic          o_sync;
    logic [2*IW-1:0] o_data;
    logic [1:0]    o_state;
    logic [15:0]   o_in_frames;
    logic [15:0]   o_out_frames;

    fft_frame_sequencer_if #(.IWIDTH(IW)) up ();

    fft_frame_sequencer #(
        .IWIDTH(IW),
        .LGWIDTH(LG),
        .PIPE_LATENCY(PL)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_stop      (stop),
        .up          (up.slave),
        .o_ce        (o_ce),
        .o_sync      (o_sync),
        .o_data      (o_data),
        .i_fft_sync  (fsync),
        .o_state     (o_state),
        .o_in_frames (o_in_frames),
        .o_out_frames(o_out_frames)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode, position within frame, pending stop,
    // flush cycles issued, frame counters and expected outputs.
    int       m_state = 0;
    int       m_pos   = 0;
    bit       m_pend  = 0;
    int       m_fi    = 0;
    int       m_in    = 0;
    int       m_out   = 0;
    bit       e_ce    = 0;
    bit       e_sync  = 0;
    logic [2*IW-1:0] e_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic leave_run();
        m_pend  = 0;
        m_fi    = 0;
        m_state = FLUSH_EN ? 2 : 0;
    endtask

    task automatic model_step();
        bit sv;
        bit st;
        sv = up.s_valid;
        if (rst) begin
            m_state = 0; m_pos = 0; m_pend = 0; m_fi = 0;
            m_in = 0; m_out = 0;
            e_ce = 0; e_sync = 0; e_data = '0;
            return;
        end
        e_ce   = 0;
        e_sync = 0;
        if (fsync) m_out = (m_out + 1) % 65536;
        case (m_state)
            0: if (start) begin m_state = 1; m_pos = 0; end
            1: begin
                st = stop || m_pend;
                if (sv) begin
                    e_ce   = 1;
                    e_data = up.s_data;
                    e_sync = (m_pos == 0);
                    if (m_pos == N - 1) m_in = (m_in + 1) % 65536;
                    m_pos = (m_pos + 1) % N;
                    if (st && m_pos == 0) leave_run();
                    else if (st) m_pend = 1;
                end else begin
                    if (st && m_pos == 0) leave_run();
                    else if (st) m_pend = 1;
                end
            end
            default: begin
                e_ce   = 1;
                e_data = '0;
                e_sync = (m_fi % N == 0);
                m_fi++;
                if (m_fi == N + PL) m_state = 0;
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("o_ce", o_ce, e_ce);
        chk("o_sync", o_sync, e_sync);
        chk("o_data", o_data, e_data);
        chk("o_state", o_state, m_state);
        chk("s_ready", up.s_ready, m_state == 1);
        chk("o_in_frames", o_in_frames, m_in);
        chk("o_out_frames", o_out_frames, m_out);
    endtask

    task automatic drain_idle(input string tag);
        int g;
        g = 0;
        up.s_valid = 0;
        while (m_state != 0 && g < 60) begin
            tick();
            g++;
        end
        chk(tag, g < 60, 1);
    endtask

    initial begin
        int g;
        int zeros;
        rst = 1; start = 0; stop = 0; fsync = 0;
        up.s_valid = 0; up.s_data = '0;
        tick();
        tick();
        chk("reset_state", o_state, 0);
        rst = 0;

        // Eight back-to-back samples 1..8
        start = 1; tick(); start = 0;
        for (int i = 1; i <= 8; i++) begin
            up.s_valid = 1; up.s_data = i; tick();
        end
        up.s_valid = 0; tick();
        chk("frames_after_8", o_in_frames, 16'd1);

        // Valid toggling 1,0
        for (int i = 0; i < 32; i++) begin
            up.s_valid = (i % 2 == 0);
            up.s_data  = $urandom;
            tick();
        end

        // Random traffic, stray starts, FFT syncs
        for (int i = 0; i < 400; i++) begin
            up.s_valid = ($urandom % 4) != 0;
            up.s_data  = $urandom;
            fsync      = ($urandom % 5) == 0;
            start      = ($urandom % 16) == 0;
            tick();
        end
        start = 0; fsync = 0;

        // Stop after sample 3 of a frame
        g = 0;
        while (m_pos != 3 && g < 40) begin
            up.s_valid = 1; up.s_data = $urandom; tick(); g++;
        end
        chk("bound_pos3", g < 40, 1);
        up.s_valid = 0; stop = 1; tick(); stop = 0;
        g = 0;
        while (m_state == 1 && g < 40) begin
            up.s_valid = 1; up.s_data = $urandom; tick(); g++;
        end
        chk("tail_samples", g, 5);
        up.s_valid = 0;
        zeros = 0;
        g = 0;
        while (m_state != 0 && g < 60) begin
            tick();
            if (o_ce === 1'b1 && o_data === '0) zeros++;
            g++;
        end
        chk("bound_flush", g < 60, 1);
        chk("flush_zeros", zeros, FLUSH_EN ? N + PL : 0);
        tick();
        chk("idle_after_stop", o_state, 0);

        // Stop at frame boundary with nothing pending; stop in IDLE
        stop = 1; tick(); stop = 0;
        start = 1; tick(); start = 0;
        stop = 1; tick(); stop = 0;
        drain_idle("bound_boundary_stop");

        // Start and stop together in IDLE: start wins
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        tick();
        chk("start_wins", o_state, 1);

        // Reset at index 5
        for (int i = 0; i < 5; i++) begin
            up.s_valid = 1; up.s_data = 32'hA000 + i; tick();
        end
        rst = 1; up.s_valid = 1; tick(); rst = 0; up.s_valid = 0;
        chk("rst_ce", o_ce, 0);
        chk("rst_frames", o_in_frames, 0);
        start = 1; tick(); start = 0;
        up.s_valid = 1; up.s_data = 32'h1234_5678; tick();
        up.s_valid = 0;
        chk("restart_sync", o_sync, 1);

        // Output frame counter wrap, starts in RUN ignored
        fsync = 1;
        for (int i = 0; i < 65536; i++) begin
            start = (i % 1000) == 7;
            tick();
        end
        fsync = 0; start = 0;
        tick();
        chk("out_wrap", o_out_frames, 16'h0000);
        chk("run_kept", o_state, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter IWIDTH, default 16, width of each real/imag component.
REQ-002 SHALL have parameter LGWIDTH, default 8, log2 of FFT frame length N.
REQ-003 SHALL have parameter PIPE_LATENCY, default 6, downstream FFT pipeline depth in ce-cycles.
REQ-004 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_start  input  1  begin streaming (pulse).
REQ-007 SHALL have port i_stop  input  1  end streaming at next frame boundary (pulse).
REQ-008 SHALL have port s_valid  input  1  upstream sample valid.
REQ-009 SHALL have port s_data  input  2*IWIDTH  sample {real, imag}.
REQ-010 SHALL have port s_ready  output  1  sample accepted when s_valid && s_ready.
REQ-011 SHALL have port o_ce  output  1  clock-enable to FFT datapath.
REQ-012 SHALL have port o_sync  output  1  first-sample-of-frame marker to FFT.
REQ-013 SHALL have port o_data  output  2*IWIDTH  sample to FFT.
REQ-014 SHALL have port i_fft_sync  input  1  frame-start marker from FFT output.
REQ-015 SHALL have port o_state  output  2  state: 0 IDLE, 1 RUN, 2 FLUSH.
REQ-016 SHALL have port o_in_frames  output  16  completed input frames, wraps.
REQ-017 SHALL have port o_out_frames  output  16  FFT output frames seen, wraps.

Function
REQ-018 IDLE: s_ready=0, o_ce=0; i_start -> RUN, sample index cleared to 0.
REQ-019 RUN: s_ready=1; i_stop sets a stop-pending flag.
REQ-020 Each handshake SHALL, next cycle, drive o_ce=1, o_data=s_data, o_sync=(index==0); otherwise o_ce=0, o_sync=0, o_data holds.
REQ-021 Latency s_data -> o_data SHALL be exactly 1 cycle; no buffering, no sample dropped or duplicated.
REQ-022 Sample index SHALL increment per handshake modulo 2^LGWIDTH; wrap N-1 -> 0 increments o_in_frames.
REQ-023 Stop-pending with index==0 (no partial frame) SHALL leave RUN that same cycle; s_ready=0 from next cycle.
REQ-024 Stop received mid-frame SHALL keep accepting until the handshake at index N-1, then leave RUN.
REQ-025 Leaving RUN SHALL go to FLUSH when flush is compiled in (REQ-033), else to IDLE; stop-pending cleared.
REQ-026 FLUSH: s_ready=0; o_ce=1 every cycle, o_data=0, for N+PIPE_LATENCY cycles, o_sync=1 on the first and every N-th flush cycle; then IDLE.
REQ-027 o_out_frames SHALL increment on every cycle where i_fft_sync=1, in any state.
REQ-028 i_start SHALL be ignored outside IDLE; i_stop SHALL be ignored outside RUN.
REQ-029 i_start and i_stop in the same IDLE cycle: start taken, stop ignored.
REQ-030 o_in_frames and o_out_frames SHALL wrap 0xFFFF -> 0x0000.

Reset
REQ-031 i_reset SHALL force, next edge, state IDLE, s_ready=0, o_ce=0, o_sync=0, o_data=0, index=0, stop-pending=0, flush counter=0, both frame counters=0.
REQ-032 Reset mid-frame or mid-flush SHALL abort immediately with no further o_ce pulse; reset has priority over all inputs.

Configuration
REQ-033 Macro FFT_SEQ_FLUSH_EN defined: FLUSH state and flush counter present per REQ-026.
REQ-034 FFT_SEQ_FLUSH_EN undefined: no FLUSH logic; RUN exits directly to IDLE; o_state never 2.

Verification
REQ-035 LGWIDTH=3, i_start, 8 back-to-back samples 1..8 -> o_ce 8 cycles, o_sync only with sample 1, o_data = samples delayed 1 cycle, o_in_frames=1.
REQ-036 LGWIDTH=3, s_valid toggling 1,0 -> o_ce mirrors handshakes 1 cycle later, index advances only on handshakes, o_sync every 8th accepted sample.
REQ-037 LGWIDTH=3, i_stop after sample 3, flush enabled, PIPE_LATENCY=6 -> samples 4..8 still accepted, then 14 zero o_ce cycles with o_sync on flush cycles 1 and 9, then o_state=0.
REQ-038 Same as REQ-037 with FFT_SEQ_FLUSH_EN undefined -> IDLE right after sample 8, no zero samples issued.
REQ-039 i_reset asserted at index 5 of a frame -> next cycle o_ce=0, o_state=0, o_in_frames=0; subsequent i_start restarts with o_sync on first sample.
REQ-040 65536 i_fft_sync pulses -> o_out_frames returns to 0x0000; i_start in RUN ignored, o_state stays 1.
